// File: rtl/move_rx_parser.sv
// move_rx_parser: rebuilds the 22-bit move word {op, row, col} from the
// 7-byte ASCII move frame and presents it through a valid/ready register.
// Optional feature: define MOVE_RX_STATS_EN to add the saturating err_count.
module move_rx_parser #(
  parameter int unsigned WIDTH_COL = 10,
  parameter int unsigned WIDTH_ROW = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  input  logic                           move_ready,
  output logic [WIDTH_ROW+WIDTH_COL+1:0] move_out,
  output logic                           move_valid,
  output logic                           frame_err,
`ifdef MOVE_RX_STATS_EN
  output logic                           overrun,
  output logic [7:0]                     err_count
`else
  output logic                           overrun
`endif
);

  typedef enum logic {RECV, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  pos_q, pos_d;
  logic [10:0] col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic [1:0]  op_q, op_d;
  logic        nul2_q, nul2_d;

  logic [WIDTH_ROW+WIDTH_COL+1:0] move_out_q, move_out_d;
  logic        move_valid_q, move_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic        done;
  logic        legal;
  logic        is_digit;
  logic        is_nul;
  logic [3:0]  digit_val;
  logic [5:0]  hi;
  logic [9:0]  row_x10;

  // Byte classification and frame-parsing FSM with incremental field build
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    col_d     = col_q;
    row_d     = row_q;
    op_d      = op_q;
    nul2_d    = nul2_q;
    done      = 1'b0;
    frame_err_d = 1'b0;
    legal     = 1'b0;
    is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_nul    = (rx_data == 8'h00);
    digit_val = is_nul ? 4'd0 : rx_data[3:0];
    // '@'+hi for hi 1..39 leaves hi in the low six bits; NUL gives 0
    hi        = rx_data[5:0];
    row_x10   = {row_q[6:0], 3'b000} + {row_q[8:0], 1'b0};

    case (pos_q)
      3'd0:    legal = (rx_data >= 8'h40) && (rx_data <= 8'h59);
      3'd1:    legal = is_nul || ((rx_data >= 8'h41) && (rx_data <= 8'h67));
      3'd2:    legal = is_nul || is_digit;
      3'd3:    legal = is_digit || (is_nul && nul2_q);
      3'd4:    legal = is_digit;
      3'd5:    legal = (rx_data == 8'h2F) || (rx_data == 8'h5C) || (rx_data == 8'h2B);
      default: legal = 1'b0;
    endcase

    if (rx_valid) begin
      case (state_q)
        RECV: begin
          if (rx_data == 8'h0A) begin
            pos_d = '0;
            if (pos_q == 3'd6 && !col_q[10]) done = 1'b1;
            else                             frame_err_d = 1'b1;
          end else if (legal && pos_q != 3'd6) begin
            pos_d = pos_q + 3'd1;
            case (pos_q)
              3'd0: begin
                col_d  = {6'b0, rx_data[4:0]};
                row_d  = '0;
                nul2_d = 1'b0;
              end
              // col += 26*hi as 16*hi + 8*hi + 2*hi
              3'd1: col_d = col_q + {1'b0, hi, 4'b0} + {2'b0, hi, 3'b0} + {4'b0, hi, 1'b0};
              3'd2: begin
                nul2_d = is_nul;
                row_d  = {6'b0, digit_val};
              end
              3'd3, 3'd4: row_d = row_x10 + {6'b0, digit_val};
              3'd5: begin
                case (rx_data)
                  8'h5C:   op_d = 2'b01;
                  8'h2B:   op_d = 2'b10;
                  default: op_d = 2'b00;
                endcase
              end
              default: ;
            endcase
          end else begin
            state_d = DISCARD;
            pos_d   = '0;
          end
        end
        DISCARD: begin
          if (rx_data == 8'h0A) begin
            frame_err_d = 1'b1;
            state_d     = RECV;
            pos_d       = '0;
          end
        end
        default: state_d = RECV;
      endcase
    end
  end

  // Output holding register: load on completion unless an unconsumed move blocks it
  always_comb begin
    move_out_d   = move_out_q;
    move_valid_d = move_valid_q;
    overrun_d    = 1'b0;
    if (done) begin
      if (!move_valid_q || move_ready) begin
        move_out_d   = {op_q, row_q[WIDTH_ROW-1:0], col_q[WIDTH_COL-1:0]};
        move_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (move_valid_q && move_ready) begin
      move_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RECV;
      pos_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      op_q         <= '0;
      nul2_q       <= 1'b0;
      move_out_q   <= '0;
      move_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      col_q        <= col_d;
      row_q        <= row_d;
      op_q         <= op_d;
      nul2_q       <= nul2_d;
      move_out_q   <= move_out_d;
      move_valid_q <= move_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign move_out   = move_out_q;
  assign move_valid = move_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

`ifdef MOVE_RX_STATS_EN
  logic [7:0] err_count_q, err_count_d;
  logic [8:0] err_sum;

  // Saturating count of rejected and dropped frames
  always_comb begin
    err_sum     = {1'b0, err_count_q} + {8'b0, frame_err_d} + {8'b0, overrun_d};
    err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= '0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_move_rx_parser.sv
module tb_move_rx_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        move_ready;
  logic [21:0] move_out;
  logic        move_valid;
  logic        frame_err;
  logic        overrun;
`ifdef MOVE_RX_STATS_EN
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  move_rx_parser #(.WIDTH_COL(10), .WIDTH_ROW(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .move_ready (move_ready),
    .move_out   (move_out),
    .move_valid (move_valid),
    .frame_err  (frame_err),
`ifdef MOVE_RX_STATS_EN
    .overrun    (overrun),
    .err_count  (err_count)
`else
    .overrun    (overrun)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bytes since the last '\n', plus the expected output register
  logic [7:0]  seg[$];
  logic        ev;
  logic [21:0] eout;
  int          ecnt;

  function automatic logic is_dig(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic int dval(input logic [7:0] b);
    return (b == 8'h00) ? 0 : int'(b) - 48;
  endfunction

  // A segment terminated by '\n' is a good move iff it is exactly six legal bytes
  function automatic logic seg_good(input logic [7:0] q[$], output logic [21:0] w);
    int lo, hi, col, row;
    logic [1:0] op;
    logic ok;
    w = '0;
    if (q.size() != 6) return 1'b0;
    ok = (q[0] >= 8'h40) && (q[0] <= 8'h59);
    ok = ok && ((q[1] == 8'h00) || ((q[1] >= 8'h41) && (q[1] <= 8'h67)));
    ok = ok && ((q[2] == 8'h00) || is_dig(q[2]));
    ok = ok && (is_dig(q[3]) || ((q[3] == 8'h00) && (q[2] == 8'h00)));
    ok = ok && is_dig(q[4]);
    case (q[5])
      8'h2F:   op = 2'd0;
      8'h5C:   op = 2'd1;
      8'h2B:   op = 2'd2;
      default: begin op = 2'd0; ok = 1'b0; end
    endcase
    if (!ok) return 1'b0;
    lo  = int'(q[0]) - 64;
    hi  = (q[1] == 8'h00) ? 0 : int'(q[1]) - 64;
    col = 26 * hi + lo;
    if (col > 1023) return 1'b0;
    row = 100 * dval(q[2]) + 10 * dval(q[3]) + dval(q[4]);
    w = {op, row[9:0], col[9:0]};
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("move_valid", {31'b0, move_valid}, {31'b0, ev});
    check("move_out",   {10'b0, move_out},   {10'b0, eout});
    check("frame_err",  {31'b0, frame_err},  {31'b0, 1'b0}); // overwritten by caller when needed
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic rdy);
    logic good, err, ovr;
    logic [21:0] w;
    @(negedge clk);
    rx_valid   = v;
    rx_data    = d;
    move_ready = rdy;
    good = 1'b0; err = 1'b0; ovr = 1'b0; w = '0;
    if (v) begin
      if (d == 8'h0A) begin
        good = seg_good(seg, w);
        err  = !good;
        seg.delete();
      end else begin
        seg.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    if (good) begin
      if (!ev || rdy) begin ev = 1'b1; eout = w; end
      else ovr = 1'b1;
    end else if (ev && rdy) begin
      ev = 1'b0;
    end
    ecnt = ecnt + int'(err) + int'(ovr);
    if (ecnt > 255) ecnt = 255;
    check("move_valid", {31'b0, move_valid}, {31'b0, ev});
    check("move_out",   {10'b0, move_out},   {10'b0, eout});
    check("frame_err",  {31'b0, frame_err},  {31'b0, err});
    check("overrun",    {31'b0, overrun},    {31'b0, ovr});
`ifdef MOVE_RX_STATS_EN
    check("err_count",  {24'b0, err_count},  32'(ecnt));
`endif
  endtask

  task automatic send(input logic [7:0] f[$], input logic rdy);
    foreach (f[i]) step(1'b1, f[i], rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    #1;
    seg.delete();
    ev = 1'b0; eout = '0; ecnt = 0;
    check("rst_move_valid", {31'b0, move_valid}, 32'd0);
    check("rst_move_out",   {10'b0, move_out},   32'd0);
    check("rst_frame_err",  {31'b0, frame_err},  32'd0);
    check("rst_overrun",    {31'b0, overrun},    32'd0);
`ifdef MOVE_RX_STATS_EN
    check("rst_err_count",  {24'b0, err_count},  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] f[$];

  initial begin
    int lo, hi, row, h, t, o, opsel;
    rst_n = 1'b1; rx_valid = 1'b0; rx_data = '0; move_ready = 1'b0;
    ev = 1'b0; eout = '0; ecnt = 0;

    do_reset();

    // col 27, row 123, op 10
    f = '{8'h41, 8'h41, 8'h31, 8'h32, 8'h33, 8'h2B, 8'h0A};
    send(f, 1'b1);
    check("tp1_word", {10'b0, move_out}, 32'h0021EC1B);
    step(1'b0, 8'h00, 1'b1);

    // col 0, row 5, op 00 with NUL padding
    f = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h35, 8'h2F, 8'h0A};
    send(f, 1'b1);
    check("tp2_word", {10'b0, move_out}, 32'h00001400);
    step(1'b0, 8'h00, 1'b1);

    // illegal hundreds digit, then a good frame
    f = '{8'h41, 8'h41, 8'h78, 8'h32, 8'h33, 8'h2B, 8'h0A};
    send(f, 1'b1);
    check("tp3_err", {31'b0, frame_err}, 32'd1);
    f = '{8'h42, 8'h00, 8'h39, 8'h39, 8'h39, 8'h5C, 8'h0A};
    send(f, 1'b1);

    // col 1039 overflow, then early newline after p2
    f = '{8'h59, 8'h67, 8'h30, 8'h30, 8'h31, 8'h5C, 8'h0A};
    send(f, 1'b1);
    check("tp4_err", {31'b0, frame_err}, 32'd1);
    f = '{8'h41, 8'h41, 8'h31, 8'h0A};
    send(f, 1'b1);
    f = '{8'h41, 8'h00, 8'h00, 8'h37, 8'h37, 8'h2F, 8'h0A};
    send(f, 1'b1);

    // consumer stalled: hold the first, drop the second
    step(1'b0, 8'h00, 1'b1);
    f = '{8'h43, 8'h44, 8'h31, 8'h30, 8'h30, 8'h2F, 8'h0A};
    send(f, 1'b0);
    f = '{8'h45, 8'h46, 8'h32, 8'h30, 8'h30, 8'h2B, 8'h0A};
    send(f, 1'b0);
    check("tp5_ovr", {31'b0, overrun}, 32'd1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // reset after p3 of a frame, then a clean frame
    f = '{8'h41, 8'h41, 8'h31, 8'h32};
    send(f, 1'b1);
    do_reset();
    f = '{8'h50, 8'h00, 8'h00, 8'h00, 8'h38, 8'h5C, 8'h0A};
    send(f, 1'b1);

    // random frames with corruption, idle gaps and random backpressure
    for (int n = 0; n < 150; n++) begin
      lo  = int'($urandom_range(0, 25));
      hi  = int'($urandom_range(0, 39));
      row = int'($urandom_range(0, 999));
      h = row / 100; t = (row / 10) % 10; o = row % 10;
      opsel = int'($urandom_range(0, 2));
      f.delete();
      f.push_back(8'(64 + lo));
      f.push_back((hi == 0) ? 8'h00 : 8'(64 + hi));
      f.push_back((h == 0 && $urandom_range(0, 1) == 1) ? 8'h00 : 8'(48 + h));
      f.push_back((f[2] == 8'h00 && t == 0 && $urandom_range(0, 1) == 1) ? 8'h00 : 8'(48 + t));
      f.push_back(8'(48 + o));
      f.push_back((opsel == 0) ? 8'h2F : (opsel == 1) ? 8'h5C : 8'h2B);
      f.push_back(8'h0A);
      if ($urandom_range(0, 3) == 0)
        f[$urandom_range(0, 6)] = 8'($urandom_range(0, 255));
      foreach (f[i]) begin
        while ($urandom_range(0, 3) == 0)
          step(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        step(1'b1, f[i], 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
